pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the MIPS fetch stage; next generation of the plain
//  6-bit incrementing PC. Holds the PC and selects the next PC: sequential, relative branch,
//  absolute jump or return. An internal return-address stack (RAS) supplies call/return targets.
//  Output pc addresses Instruction_Memory directly. One PC update per enabled clock edge.
// PARAMETERS
//  PC_W       32      PC width in bits (>= 8)
//  INC        4       sequential increment in bytes (power of 2); low log2(INC) PC bits always 0
//  OFF_W      16      branch offset width (signed, in instructions)
//  RESET_VEC  0       PC value after reset (must be INC-aligned)
//  RAS_DEPTH  4       return-address-stack entries (power of 2, >= 2)
// PORTS
//  clk            in   1        clock; all state changes on posedge
//  reset          in   1        synchronous, active-high
//  enable         in   1        1 = advance PC this cycle; 0 = hold everything (stall)
//  branch_taken   in   1        take relative branch
//  branch_off     in   OFF_W    signed instruction offset relative to pc+INC
//  jump           in   1        take absolute jump
//  jump_addr      in   PC_W     absolute jump target
//  call           in   1        push pc+INC onto RAS (qualifies jump or branch_taken)
//  ret            in   1        pop RAS, next PC = popped value
//  pc             out  PC_W     current PC (registered)
//  pc_plus        out  PC_W     pc+INC, combinational, wraps mod 2^PC_W
//  ras_count      out  clog2(RAS_DEPTH)+1  valid RAS entries (0..RAS_DEPTH)
//  ras_ovf        out  1        sticky: push occurred while full
//  ras_unf        out  1        sticky: pop occurred while empty
// BEHAVIOUR
//  Reset (sync, highest priority): pc=RESET_VEC, ras_count=0, ras_ovf=0, ras_unf=0.
//   RAS entry contents are don't-care after reset. Reset mid-stall or mid-return behaves the same.
//  enable=0: pc, RAS, count and flags all hold; call/ret/jump/branch are ignored (not queued).
//  enable=1 next-PC priority: ret > jump > branch_taken > sequential (pc+INC).
//   Branch target = pc + INC + sext(branch_off)*INC, modulo 2^PC_W (wraps silently).
//   Jump target = jump_addr with low log2(INC) bits forced to 0.
//   Sequential at pc = 2^PC_W-INC wraps to 0.
//  Latency: target visible on pc the cycle after the qualifying edge; no bubbles are inserted.
//  RAS (only when enable=1):
//   call alone (with jump/branch): push pc+INC; the call is ignored if neither jump nor branch_taken.
//   push when full: overwrite the oldest entry (circular), count stays RAS_DEPTH, set ras_ovf.
//   ret, count>0: next pc = top entry, count-1.
//   ret, count=0: next pc = pc+INC, count stays 0, set ras_unf.
//   ret+call same cycle: next pc = old top; top is then replaced by pc+INC, count unchanged.
//    If count=0: set ras_unf, next pc = pc+INC, push pc+INC -> count=1.
//  ras_ovf/ras_unf clear only on reset.
// STRUCTURE
//  Shared header pc_defs.vh: default PC_W/INC/RESET_VEC and next-PC select encodings
//   (SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET) used by pc_unit and the control unit.
//  Sub-module pc_ras (DEPTH, W): circular stack with push/pop/top/count/ovf/unf.
//   Top = (wr_ptr-1) mod DEPTH. Pop-then-push in the same cycle writes the top slot.
//  pc_unit: next-PC mux, the PC register and pc_ras instance. Combinational next-PC, single always block.
// TESTING
//  1 reset=1 for 2 clk, then enable=1 for 4 clk -> pc 0,4,8,12,16; enable=0 for 3 clk -> pc holds 16.
//  2 pc=0x100, branch_taken=1, branch_off=-3 -> pc=0xF8; same cycle with jump=1, jump_addr=0x2003
//    -> pc=0x2000 (jump wins; low bits masked).
//  3 call+jump at pc=0x40, then 0x80, 0xC0 (targets 0x200, 0x300, 0x400); three ret
//    -> pc 0xC4, 0x84, 0x44; ras_count 3->0; a fourth ret -> pc+4, ras_unf=1.
//  4 RAS_DEPTH=4: five call+jump -> ras_count=4, ras_ovf=1; five ret -> the four newest
//    return addresses in LIFO order, then ras_unf=1.
//  5 ret+call same cycle with count=2 -> pc=old top, count stays 2, new top=pc+4;
//    then reset during a stall -> pc=RESET_VEC, count=0, both flags 0.
//  6 PC_W=8, pc=0xFC, sequential -> pc=0x00; branch_off=+1 at 0xF8 -> pc=0x00 (wrap, no flag).

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared defaults and next-PC select encodings for the fetch-stage PC unit and the control unit.
// Pure declarations; no logic or state.
package pc_unit_pkg;

    localparam int          DEF_PC_W      = 32;
    localparam int          DEF_INC       = 4;
    localparam int          DEF_OFF_W     = 16;
    localparam int          DEF_RAS_DEPTH = 4;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JMP = 2'd2,
        SEL_RET = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; push/pop take effect on the clock edge, top_dat is combinational.
// No backpressure: push when full drops the oldest entry (ovf), pop when empty is a no-op (unf).
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_dat,
    output logic [W-1:0]  top_dat,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          unf
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] top_ptr;
    logic          empty;
    logic          full;
    logic          swap;

    assign top_ptr = wr_ptr - PW'(1);
    assign top_dat = mem[top_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // Pop-then-push on a non-empty stack rewrites the top slot in place.
    assign swap    = push && pop && !empty;

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            if (swap)
                mem[top_ptr] <= push_dat;
            else
                mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (pop && empty)
                unf <= 1'b1;
            if (pop && !empty && !push) begin
                wr_ptr <= top_ptr;
                count  <= count - CW'(1);
            end else if (push && !swap) begin
                // When full, wr_ptr already points at the oldest entry.
                wr_ptr <= wr_ptr + PW'(1);
                if (full)
                    ovf <= 1'b1;
                else
                    count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with branch/jump/return selection and a return-address stack; 1-cycle latency.
// enable=0 stalls the PC, the stack and its flags; control inputs seen during a stall are dropped.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              PC_W      = DEF_PC_W,
    parameter int              INC       = DEF_INC,
    parameter int              OFF_W     = DEF_OFF_W,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEF_RESET_VEC),
    parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         branch_taken,
    input  logic [OFF_W-1:0]             branch_off,
    input  logic                         jump,
    input  logic [PC_W-1:0]              jump_addr,
    input  logic                         call,
    input  logic                         ret,
    output logic [PC_W-1:0]              pc,
    output logic [PC_W-1:0]              pc_plus,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int              SH         = $clog2(INC);
    localparam int              CW         = $clog2(RAS_DEPTH) + 1;
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(INC - 1);

    pc_sel_e         sel;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;

    assign pc_plus  = pc + PC_W'(INC);
    assign off_ext  = PC_W'($signed(branch_off));
    assign br_tgt   = pc_plus + (off_ext << SH);
    // A call only pushes when it accompanies a control transfer (including a return).
    assign ras_pop  = enable && ret;
    assign ras_push = enable && call && (ret || jump || branch_taken);

    always_comb begin
        sel = SEL_SEQ;
        if (ret)
            sel = (ras_count != '0) ? SEL_RET : SEL_SEQ;
        else if (jump)
            sel = SEL_JMP;
        else if (branch_taken)
            sel = SEL_BR;

        pc_nxt = pc_plus;
        case (sel)
            SEL_RET: pc_nxt = ras_top;
            SEL_JMP: pc_nxt = jump_addr & ALIGN_MASK;
            SEL_BR:  pc_nxt = br_tgt;
            default: pc_nxt = pc_plus;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            pc <= RESET_VEC;
        else if (enable)
            pc <= pc_nxt;
    end

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W),
        .CW    (CW)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_dat (pc_plus),
        .top_dat  (ras_top),
        .count    (ras_count),
        .ovf      (ras_ovf),
        .unf      (ras_unf)
    );

endmodule
